// File: rtl/draw_sequencer.sv
// Three-digit draw sequencer: captures digits on press, judges a triple
// match, and blinks the win light from the low-rate tick strobe.
module draw_sequencer #(
   parameter int sim         = 0,
   parameter int BLINK_TICKS = (sim != 0) ? 2 : 64
) (
   input  logic       clk,
   input  logic       resetIn,
   input  logic       press,
   input  logic [3:0] rand_val,
   input  logic       tick_in,
   output logic [3:0] d0,
   output logic [3:0] d1,
   output logic [3:0] d2,
   output logic [2:0] d_valid,
   output logic [1:0] draw_cnt,
   output logic       done,
   output logic       light_win
);

   typedef enum logic [2:0] {
      IDLE,
      HAVE1,
      HAVE2,
      JUDGE,
      DONE
   } state_e;

   localparam int CW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_TICKS - 1);

   state_e        state_q, state_d;
   logic [3:0]    d0_q, d0_d;
   logic [3:0]    d1_q, d1_d;
   logic [3:0]    d2_q, d2_d;
   logic [2:0]    dv_q, dv_d;
   logic [1:0]    cnt_q, cnt_d;
   logic          done_q, done_d;
   logic          win_q, win_d;
   logic          light_q, light_d;
   logic [CW-1:0] blink_q, blink_d;
   logic [3:0]    digit;
   logic          match;

   // Codes 10-15 fold back onto 0-5 so every stored digit is decimal.
   assign digit = (rand_val <= 4'd9) ? rand_val : rand_val - 4'd10;
   assign match = (d0_q == d1_q) && (d1_q == d2_q);

   always_comb begin
      state_d = state_q;
      d0_d    = d0_q;
      d1_d    = d1_q;
      d2_d    = d2_q;
      dv_d    = dv_q;
      cnt_d   = cnt_q;
      win_d   = win_q;
      light_d = light_q;
      blink_d = blink_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (press) begin
               state_d = HAVE1;
               d0_d    = digit;
               d1_d    = 4'd0;
               d2_d    = 4'd0;
               dv_d    = 3'b001;
               cnt_d   = 2'd1;
               win_d   = 1'b0;
               light_d = 1'b0;
               blink_d = '0;
            end else if (state_q == DONE && win_q && tick_in) begin
               if (blink_q == CNT_LAST) begin
                  blink_d = '0;
                  light_d = ~light_q;
               end else begin
                  blink_d = blink_q + 1'b1;
               end
            end
         end
         HAVE1: begin
            if (press) begin
               state_d = HAVE2;
               d1_d    = digit;
               dv_d    = 3'b011;
               cnt_d   = 2'd2;
            end
         end
         HAVE2: begin
            if (press) begin
               state_d = JUDGE;
               d2_d    = digit;
               dv_d    = 3'b111;
               cnt_d   = 2'd3;
            end
         end
         JUDGE: begin
            state_d = DONE;
            win_d   = match;
            light_d = match;
            blink_d = '0;
         end
         default: state_d = IDLE;
      endcase
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (!resetIn) begin
         state_q <= IDLE;
         d0_q    <= 4'd0;
         d1_q    <= 4'd0;
         d2_q    <= 4'd0;
         dv_q    <= 3'b000;
         cnt_q   <= 2'd0;
         done_q  <= 1'b0;
         win_q   <= 1'b0;
         light_q <= 1'b0;
         blink_q <= '0;
      end else begin
         state_q <= state_d;
         d0_q    <= d0_d;
         d1_q    <= d1_d;
         d2_q    <= d2_d;
         dv_q    <= dv_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         win_q   <= win_d;
         light_q <= light_d;
         blink_q <= blink_d;
      end
   end

   assign d0        = d0_q;
   assign d1        = d1_q;
   assign d2        = d2_q;
   assign d_valid   = dv_q;
   assign draw_cnt  = cnt_q;
   assign done      = done_q;
   assign light_win = light_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer (sim=1, blink every 2 ticks).
module tb_draw_sequencer;

   logic       clk = 1'b0;
   logic       resetIn;
   logic       press;
   logic [3:0] rand_val;
   logic       tick_in;
   logic [3:0] d0, d1, d2;
   logic [2:0] d_valid;
   logic [1:0] draw_cnt;
   logic       done;
   logic       light_win;

   int n_cmp = 0;
   int n_err = 0;

   draw_sequencer #(.sim(1)) dut (
      .clk      (clk),
      .resetIn  (resetIn),
      .press    (press),
      .rand_val (rand_val),
      .tick_in  (tick_in),
      .d0       (d0),
      .d1       (d1),
      .d2       (d2),
      .d_valid  (d_valid),
      .draw_cnt (draw_cnt),
      .done     (done),
      .light_win(light_win)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag,
                          input logic [3:0] e0, input logic [3:0] e1,
                          input logic [3:0] e2, input logic [2:0] ev,
                          input logic [1:0] ec, input logic ed,
                          input logic el);
      chk({tag, ".d0"}, {4'd0, d0}, {4'd0, e0});
      chk({tag, ".d1"}, {4'd0, d1}, {4'd0, e1});
      chk({tag, ".d2"}, {4'd0, d2}, {4'd0, e2});
      chk({tag, ".dv"}, {5'd0, d_valid}, {5'd0, ev});
      chk({tag, ".cnt"}, {6'd0, draw_cnt}, {6'd0, ec});
      chk({tag, ".done"}, {7'd0, done}, {7'd0, ed});
      chk({tag, ".light"}, {7'd0, light_win}, {7'd0, el});
   endtask

   // Apply one cycle of inputs, then sample 1 ns after the edge.
   task automatic cyc(input logic rst_n, input logic p,
                      input logic [3:0] rv, input logic t);
      resetIn  = rst_n;
      press    = p;
      rand_val = rv;
      tick_in  = t;
      @(posedge clk);
      #1;
      press   = 1'b0;
      tick_in = 1'b0;
   endtask

   initial begin
      resetIn  = 1'b0;
      press    = 1'b0;
      rand_val = 4'd0;
      tick_in  = 1'b0;

      cyc(0, 1, 4'd7, 1);
      cyc(0, 0, 4'd0, 0);
      chk_all("reset", 0, 0, 0, 3'b000, 0, 0, 0);

      // Round 1: 4,4,4 -> win
      cyc(1, 1, 4'd4, 0);
      chk_all("r1p1", 4, 0, 0, 3'b001, 1, 0, 0);
      cyc(1, 0, 4'd2, 1);
      chk_all("r1hold", 4, 0, 0, 3'b001, 1, 0, 0);
      cyc(1, 1, 4'd4, 0);
      chk_all("r1p2", 4, 4, 0, 3'b011, 2, 0, 0);
      cyc(1, 1, 4'd4, 0);
      chk_all("r1p3", 4, 4, 4, 3'b111, 3, 0, 0);
      // press held through JUDGE is ignored
      cyc(1, 1, 4'd5, 1);
      chk_all("r1judge", 4, 4, 4, 3'b111, 3, 1, 1);
      cyc(1, 0, 4'd0, 1);
      chk("blink1", {7'd0, light_win}, 8'd1);
      cyc(1, 0, 4'd0, 0);
      chk("blink_idle", {7'd0, light_win}, 8'd1);
      cyc(1, 0, 4'd0, 1);
      chk("blink2", {7'd0, light_win}, 8'd0);
      cyc(1, 0, 4'd0, 1);
      chk("blink3", {7'd0, light_win}, 8'd0);
      cyc(1, 0, 4'd0, 1);
      chk("blink4", {7'd0, light_win}, 8'd1);

      // Press coinciding with tick in DONE starts a new round
      cyc(1, 1, 4'd9, 1);
      chk_all("r2p1", 9, 0, 0, 3'b001, 1, 0, 0);
      cyc(1, 1, 4'd15, 0);
      chk_all("r2p2", 9, 5, 0, 3'b011, 2, 0, 0);
      cyc(1, 1, 4'd10, 0);
      chk_all("r2p3", 9, 5, 0, 3'b111, 3, 0, 0);
      cyc(1, 0, 4'd0, 0);
      chk_all("r2done", 9, 5, 0, 3'b111, 3, 1, 0);

      // Round 3: 3,12,7 -> no win
      cyc(1, 1, 4'd3, 0);
      chk_all("r3p1", 3, 0, 0, 3'b001, 1, 0, 0);
      cyc(1, 1, 4'd12, 0);
      chk_all("r3p2", 3, 2, 0, 3'b011, 2, 0, 0);
      cyc(1, 1, 4'd7, 0);
      chk_all("r3p3", 3, 2, 7, 3'b111, 3, 0, 0);
      cyc(1, 0, 4'd0, 0);
      chk_all("r3done", 3, 2, 7, 3'b111, 3, 1, 0);
      for (int i = 0; i < 10; i++) begin
         cyc(1, 0, 4'd0, 1);
         chk("r3nolight", {7'd0, light_win}, 8'd0);
      end

      // Reset after two presses, press in the reset cycle ignored
      cyc(1, 1, 4'd6, 0);
      cyc(1, 1, 4'd8, 0);
      chk_all("r4p2", 6, 8, 0, 3'b011, 2, 0, 0);
      cyc(0, 1, 4'd1, 1);
      chk_all("r4rst", 0, 0, 0, 3'b000, 0, 0, 0);
      cyc(1, 1, 4'd2, 0);
      chk_all("r4p1", 2, 0, 0, 3'b001, 1, 0, 0);

      // Reset during JUDGE discards the round
      cyc(1, 1, 4'd2, 0);
      cyc(1, 1, 4'd2, 0);
      chk_all("r5p3", 2, 2, 2, 3'b111, 3, 0, 0);
      cyc(0, 0, 4'd0, 0);
      chk_all("r5rst", 0, 0, 0, 3'b000, 0, 0, 0);
      cyc(1, 0, 4'd0, 1);
      chk_all("r5after", 0, 0, 0, 3'b000, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/draw_sequencer.md
DRAW_SEQUENCER -- requirements
Module: draw_sequencer

Interface
REQ-001 The block SHALL have parameter sim, default 0, meaning simulation timing select (1 = shortened blink period).
REQ-002 The block SHALL have parameter BLINK_TICKS, default (sim ? 2 : 64), meaning tick_in strobes per light_win toggle.
REQ-003 The block SHALL have port clk  input  1  system clock, single clock domain.
REQ-004 The block SHALL have port resetIn  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port press  input  1  debounced button strobe, one clk cycle wide per press.
REQ-006 The block SHALL have port rand_val  input  4  free-running random source value, any code 0-15.
REQ-007 The block SHALL have port tick_in  input  1  one-cycle strobe derived from the 128 Hz low clock.
REQ-008 The block SHALL have port d0, d1, d2  output  4 each  captured draw digits, 0-9.
REQ-009 The block SHALL have port d_valid  output  3  per-digit valid; bit i qualifies di for display blanking.
REQ-010 The block SHALL have port draw_cnt  output  2  number of digits captured in the current round, 0-3.
REQ-011 The block SHALL have port done  output  1  round complete, judgement available.
REQ-012 The block SHALL have port light_win  output  1  win indicator, blinking.

Function
REQ-013 The FSM SHALL have states IDLE, HAVE1, HAVE2, JUDGE, DONE.
REQ-014 Digit capture SHALL store rand_val when rand_val <= 9, else rand_val - 10, so stored digits are always 0-9.
REQ-015 A press sampled in cycle n SHALL update the digit register, d_valid, draw_cnt and state at the clock edge ending cycle n, one-cycle latency.
REQ-016 A press in IDLE SHALL write d0, set d_valid=3'b001, draw_cnt=1, and go to HAVE1.
REQ-017 A press in HAVE1 SHALL write d1, set d_valid=3'b011, draw_cnt=2, and go to HAVE2.
REQ-018 A press in HAVE2 SHALL write d2, set d_valid=3'b111, draw_cnt=3, and go to JUDGE.
REQ-019 JUDGE SHALL last exactly one cycle: register win = (d0==d1 && d1==d2), go to DONE, and ignore press.
REQ-020 In DONE, done SHALL be 1; done SHALL be 0 in every other state.
REQ-021 A press in DONE SHALL start a new round: clear d1, d2 and win, write d0, set d_valid=3'b001, draw_cnt=1, and go to HAVE1, all on the same edge.
REQ-022 Without press, all states except JUDGE SHALL hold, and digits SHALL hold their values.
REQ-023 Blink counter: in DONE with win=1, each tick_in SHALL increment the counter; on reaching BLINK_TICKS-1 it SHALL wrap to 0 and toggle light_win.
REQ-024 On entry to DONE with win=1, light_win SHALL go to 1 on the same edge, with the blink counter at 0.
REQ-025 In any state other than DONE, or with win=0, light_win SHALL be 0 and the blink counter 0.
REQ-026 If tick_in and press coincide in DONE, press SHALL win: start the new round and force light_win=0.
REQ-027 tick_in SHALL be ignored outside DONE.

Reset
REQ-028 When resetIn=0 at a clk edge, the block SHALL set state=IDLE, d0=d1=d2=0, d_valid=0, draw_cnt=0, done=0, win=0, light_win=0 and blink counter 0.
REQ-029 Reset SHALL take priority over press and tick_in in the same cycle.
REQ-030 Reset mid-round, including during JUDGE, SHALL discard all captured digits.
REQ-031 Outputs SHALL be registered; there SHALL be no combinational path from press to any output.

Verification
REQ-032 Scenario: three presses with rand_val=4, 4, 4, sim=1 -> d0..d2=4, d_valid=111, done=1 two edges after the third press, light_win=1 then toggling every 2 tick_in.
REQ-033 Scenario: presses with rand_val=3, 12, 7 -> d0=3, d1=2, d2=7, done=1, light_win stays 0 across 10 ticks.
REQ-034 Scenario: resetIn=0 for one cycle after two presses -> all outputs zero next edge; the next press captures into d0, draw_cnt=1.
REQ-035 Scenario: press held asserted in the JUDGE cycle -> ignored, state=DONE, draw_cnt=3.
REQ-036 Scenario: fourth press (rand_val=9) in DONE with light_win=1, coinciding with tick_in -> d0=9, d1=d2=0, d_valid=001, done=0, light_win=0.
REQ-037 Scenario: rand_val=15 captured -> digit 5; rand_val=10 -> digit 0.
